blink_period_meter: RTL and testbench
=====================================

BLINK_PERIOD_METER -- requirements
Module: blink_period_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, the stable-level count used only when BLINK_DEBOUNCE_EN is defined.
REQ-003 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pulse_in  input  1  asynchronous blink/LED signal to be measured.
REQ-006 SHALL have port period_ms  output  16  the last completed rising-edge-to-rising-edge period, in ms.
REQ-007 SHALL have port period_valid  output  1  one-clk pulse when period_ms updates.
REQ-008 SHALL have port timeout  output  1  sticky flag: no edge for 65535 ms.
REQ-009 SHALL have port measuring  output  1  high while in state MEASURE.

Function
REQ-010 SHALL pass pulse_in through a 2-FF synchronizer, then detect a rising edge with a 1-FF delayed copy.
REQ-011 SHALL derive a ms tick from prescaler TICKS_PER_MS = CLK_FREQ_HZ/1000: tick high for one clk when the prescaler equals TICKS_PER_MS-1, then the prescaler wraps to 0.
REQ-012 SHALL clear the prescaler in the cycle after every accepted rising edge, so period_ms = floor(edge-to-edge clk cycles / TICKS_PER_MS).
REQ-013 SHALL implement FSM IDLE -> MEASURE on the first rising edge, with ms_count cleared to 0.
REQ-014 SHALL, in MEASURE, on each rising edge load period_ms <= ms_count (+1 if a tick coincides), pulse period_valid, clear ms_count and timeout, and stay in MEASURE.
REQ-015 SHALL, in MEASURE, increment ms_count on each tick.
REQ-016 SHALL, in MEASURE, on reaching 16'hFFFF set timeout, go to IDLE, and hold period_ms unchanged.
REQ-017 SHALL NOT assert period_valid for the first edge after reset or after a timeout.
REQ-018 SHALL assert period_valid exactly 3 clks after the clk edge that first samples pulse_in high (no debounce).
REQ-019 SHALL report a period of 0 ms (valid still pulsed) for edges closer together than TICKS_PER_MS cycles.
REQ-020 SHALL register all outputs; no combinational path from pulse_in to any output.
REQ-021 SHALL ignore falling edges; duty cycle does not affect the result.

Reset
REQ-022 SHALL, while reset_n = 0, force period_ms = 0, period_valid = 0, timeout = 0, measuring = 0, FSM = IDLE, prescaler = 0, ms_count = 0, and synchronizer/debounce = 0.
REQ-023 SHALL discard any in-progress measurement on reset mid-operation; the first edge after release only arms the FSM.

Configuration
REQ-024 SHALL, with BLINK_DEBOUNCE_EN defined, accept a level change only after the synchronized input is stable for DEBOUNCE_CYCLES consecutive clks; this adds DEBOUNCE_CYCLES clks of latency to REQ-018.
REQ-025 SHALL, without BLINK_DEBOUNCE_EN, use the synchronizer only, with no debounce logic present.

Structure
REQ-026 SHALL place the FSM state typedef (IDLE, MEASURE), MS_COUNT_W = 16 and MS_MAX = 16'hFFFF in package blink_pkg.
REQ-027 SHALL implement the prescaler as sub-module ms_tick_gen (ports clk, reset_n, clr, tick).

Verification (CLK_FREQ_HZ = 10_000, so TICKS_PER_MS = 10)
REQ-028 SHALL cover: rising edges at cycles 0, 50, 100 -> no valid for the first edge; period_valid with period_ms = 5 twice; measuring = 1 after the first edge.
REQ-029 SHALL cover: edges 37 cycles apart -> period_ms = 3; edges 5 cycles apart -> period_ms = 0 with period_valid = 1.
REQ-030 SHALL cover: no edge for 655350 cycles after arming -> timeout = 1, measuring = 0, period_ms unchanged; next edge gives no valid; the following edge 20 cycles later gives period_ms = 2 and clears timeout.
REQ-031 SHALL cover: reset_n low for 3 cycles mid-period -> all outputs 0 immediately; the next two edges 30 cycles apart yield exactly one valid with period_ms = 3.
REQ-032 SHALL cover: BLINK_DEBOUNCE_EN defined, DEBOUNCE_CYCLES = 4, 2-cycle glitch on pulse_in -> no edge accepted; a clean edge gives period_valid at 3 + 4 clks latency.
REQ-033 SHALL cover: high-duty (45/50 cycles) vs low-duty (5/50 cycles) input at the same period -> identical period_ms = 5.

Source files
------------

// File: rtl/blink_pkg.sv
// blink_pkg: shared FSM state type and ms-counter constants for blink_period_meter
package blink_pkg;
  typedef enum logic {IDLE, MEASURE} state_e;
  localparam int MS_COUNT_W = 16;
  localparam logic [MS_COUNT_W-1:0] MS_MAX = 16'hFFFF;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-clk tick every TICKS_PER_MS cycles, restartable by clr
module ms_tick_gen #(
  parameter int TICKS_PER_MS = 100_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int W = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_MS - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (clr || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tick = cnt_q == LAST;
endmodule

// File: rtl/blink_period_meter.sv
// blink_period_meter: rising-edge-to-rising-edge period of pulse_in in ms, with sticky timeout.
// Define BLINK_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable clks before a level change is accepted.
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pulse_in,
  output logic [MS_COUNT_W-1:0] period_ms,
  output logic                  period_valid,
  output logic                  timeout,
  output logic                  measuring
);
  localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000;
  if (TICKS_PER_MS < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("blink_period_meter: need CLK_FREQ_HZ >= 1000 and DEBOUNCE_CYCLES >= 1");
  end
  state_e state_q, state_d;
  logic sync1_q, sync2_q, lvl, dly_q, rise_q, tick;
  logic [MS_COUNT_W-1:0] ms_q, ms_d, per_q, per_d;
  logic vld_q, vld_d, to_q, to_d;
`ifdef BLINK_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  // counter runs only while the synchronized level disagrees with the accepted one
  always_comb begin
    db_d = (sync2_q != db_q && db_cnt_q == DB_LAST) ? sync2_q : db_q;
    db_cnt_d = (sync2_q != db_q && db_cnt_q != DB_LAST) ? db_cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_q <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  assign lvl = db_q;
`else
  assign lvl = sync2_q;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {sync1_q, sync2_q, dly_q, rise_q} <= '0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      dly_q <= lvl;
      rise_q <= lvl & ~dly_q;
    end
  ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .clr(rise_q),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // an edge wins over a simultaneous counter saturation
  always_comb
    state_d = (state_q == IDLE) ? (rise_q ? MEASURE : IDLE)
                                : ((!rise_q && ms_q == MS_MAX) ? IDLE : MEASURE);
  always_comb begin
    ms_d = ms_q;
    per_d = per_q;
    to_d = to_q;
    vld_d = 1'b0;
    if (rise_q) begin
      ms_d = '0;
      if (state_q == MEASURE) begin
        per_d = ms_q + MS_COUNT_W'(tick);
        vld_d = 1'b1;
        to_d = 1'b0;
      end
    end else if (state_q == MEASURE) begin
      if (ms_q == MS_MAX) to_d = 1'b1;
      else if (tick) ms_d = ms_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ms_q <= '0;
      per_q <= '0;
      vld_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      ms_q <= ms_d;
      per_q <= per_d;
      vld_q <= vld_d;
      to_q <= to_d;
    end
  assign period_ms = per_q;
  assign period_valid = vld_q;
  assign timeout = to_q;
  assign measuring = state_q == MEASURE;
endmodule

// File: tb/tb_blink_period_meter.sv
// tb_blink_period_meter: randomized scoreboard bench; dut0 at 10 clks/ms, dut1 at 1 clk/ms for timeout
module tb_blink_period_meter;
  localparam int DEB = 4;
`ifdef BLINK_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  typedef struct {int cyc; int per;} exp_t;
  logic clk = 1'b0;
  logic rst_n [2];
  logic pin [2];
  logic [15:0] per [2];
  logic vld [2];
  logic to [2];
  logic meas [2];
  int tpm [2] = '{10, 1};
  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  exp_t sbq [2][$];
  exp_t e_m;
  int last [2];
  bit armed [2];
  bit exp_to [2];
  int exp_per [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  blink_period_meter #(.CLK_FREQ_HZ(10_000), .DEBOUNCE_CYCLES(DEB)) dut0 (
    .clk(clk), .reset_n(rst_n[0]), .pulse_in(pin[0]),
    .period_ms(per[0]), .period_valid(vld[0]), .timeout(to[0]), .measuring(meas[0])
  );
  blink_period_meter #(.CLK_FREQ_HZ(1_000), .DEBOUNCE_CYCLES(DEB)) dut1 (
    .clk(clk), .reset_n(rst_n[1]), .pulse_in(pin[1]),
    .period_ms(per[1]), .period_valid(vld[1]), .timeout(to[1]), .measuring(meas[1])
  );
  task automatic check(input string nm, input int d, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s dut%0d at cycle %0d: got %0d, expected %0d", nm, d, cyc, act, exp);
    end
  endtask
  // the meter gives up once 65535 ms pass with no edge; the window right at that limit is never stimulated
  function automatic bit expired(input int d);
    return armed[d] && (cyc - last[d]) > 65535 * tpm[d] + LAT + 2;
  endfunction
  task automatic pulse(input int d, input int hi, input int gap);
    bit acc;
`ifdef BLINK_DEBOUNCE_EN
    acc = hi >= DEB;
`else
    acc = 1'b1;
`endif
    if (acc) begin
      if (expired(d)) exp_to[d] = 1'b1;
      else if (armed[d]) begin
        exp_per[d] = (cyc - last[d]) / tpm[d];
        exp_to[d] = 1'b0;
        sbq[d].push_back('{cyc + 1 + LAT, exp_per[d]});
      end
      armed[d] = 1'b1;
      last[d] = cyc;
    end
    pin[d] = 1'b1;
    repeat (hi) @(negedge clk);
    pin[d] = 1'b0;
    repeat (gap - hi) @(negedge clk);
  endtask
  task automatic chk_out(input int d);
    check("period_ms", d, int'(per[d]), exp_per[d]);
    check("timeout", d, int'(to[d]), int'(exp_to[d] || expired(d)));
    check("measuring", d, int'(meas[d]), int'(armed[d] && !expired(d)));
  endtask
  task automatic reset_model(input int d);
    armed[d] = 1'b0;
    exp_to[d] = 1'b0;
    exp_per[d] = 0;
  endtask
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (vld[d]) begin
        if (sbq[d].size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_valid dut%0d at cycle %0d: got valid with period_ms=%0d, expected none", d, cyc, per[d]);
        end else begin
          e_m = sbq[d].pop_front();
          check("valid_cycle", d, cyc, e_m.cyc);
          check("valid_period_ms", d, int'(per[d]), e_m.per);
        end
      end
  initial begin
    int gap, hi;
    rst_n = '{1'b0, 1'b0};
    pin = '{1'b0, 1'b0};
    for (int d = 0; d < 2; d++) reset_model(d);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_period_ms", d, int'(per[d]), 0);
      check("rst_valid", d, int'(vld[d]), 0);
      check("rst_timeout", d, int'(to[d]), 0);
      check("rst_measuring", d, int'(meas[d]), 0);
    end
    rst_n = '{1'b1, 1'b1};
    repeat (2) @(negedge clk);
    pulse(0, 20, 50);
    chk_out(0);
    pulse(0, 20, 50);
    pulse(0, 20, 50);
    chk_out(0);
    pulse(0, 10, 37);
`ifdef BLINK_DEBOUNCE_EN
    pulse(0, 2, 30);
`else
    pulse(0, 2, 5);
`endif
    pulse(0, 10, 40);
    chk_out(0);
    for (int i = 0; i < 3; i++) pulse(0, 45, 50);
    for (int i = 0; i < 3; i++) pulse(0, 5, 50);
    chk_out(0);
    repeat (20) begin
      gap = $urandom_range(400, 12);
      hi = $urandom_range(gap - 6, 6);
      pulse(0, hi, gap);
    end
    chk_out(0);
    pulse(0, 10, 25);
    rst_n[0] = 1'b0;
    #1;
    check("midrst_period_ms", 0, int'(per[0]), 0);
    check("midrst_valid", 0, int'(vld[0]), 0);
    check("midrst_timeout", 0, int'(to[0]), 0);
    check("midrst_measuring", 0, int'(meas[0]), 0);
    reset_model(0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    pulse(0, 10, 30);
    pulse(0, 10, 30);
    chk_out(0);
    pulse(1, 10, 20);
    pulse(1, 10, 65535 + 40);
    chk_out(1);
    pulse(1, 10, 20);
    chk_out(1);
    pulse(1, 10, 20);
    chk_out(1);
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) check("scoreboard_drained", d, sbq[d].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
